assist_pi_sequencer: RTL and testbench
======================================

Name: assist_pi_sequencer

Overview:
Multi-cycle sequencer for the heart-rate PI assistance datapath. It samples HeartRate and HeartRateSetPoint on each update strobe from the ANT+ front end and steps a shared multiply/accumulate path through error, integral, sum and saturation states. It enforces the safety interlocks (tilt, brake, cadence stall) before driving AssistanceRequirement to the downstream motor filter/PWM stage.

Parameters:
KP, 2, proportional gain, unsigned 4-bit integer
KI, 1, integral gain, unsigned 4-bit integer
I_SHIFT, 2, arithmetic right shift applied to KI*integ
INT_LIMIT, 2000, symmetric integrator clamp (|integ| <= INT_LIMIT)
TILT_LIMIT, 128, tilt fault threshold on |roll| and |pitch|, same units as the IMU inputs
CAD_TIMEOUT, 50000000, clk cycles without a cadence rising edge before the block declares a stall
RAMP_STEP, 16, maximum output change per update (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hr_valid  in  1  single-cycle strobe: new HeartRate sample
HeartRate  in  8  current heart rate, bpm, unsigned
HeartRateSetPoint  in  8  user set point, bpm, unsigned
resolvedRoll  in  10  signed roll angle
resolvedPitch  in  10  signed pitch angle
cadence  in  1  pedal cadence pulse, asynchronous; 2-FF synchronised internally
brake  in  1  brake lever, level, active-high
AssistanceRequirement  out  10  signed assistance command, range 0..511
out_valid  out  1  one-cycle pulse when AssistanceRequirement updates
busy  out  1  high in every FSM state except IDLE
fault  out  1  tilt fault latched
stalled  out  1  cadence timeout active

Behaviour:
- Reset (async, rst_n=0): AssistanceRequirement=0, out_valid=0, busy=0, fault=0, stalled=1, integ=0, FSM=IDLE, cadence counter=0.
- FSM: IDLE -> SAMPLE -> ERR -> INTEG -> SUM -> SAT -> IDLE. One state per clk.
- IDLE: on hr_valid=1, go to SAMPLE.
- SAMPLE: latch HeartRate and set point into internal registers.
- ERR: err = HR - SP, 9-bit signed. Positive err means more assistance.
- INTEG: integ += err, clamped to +/-INT_LIMIT; integ is 16-bit signed.
- SUM: sum = KP*err + ((KI*integ) >>> I_SHIFT), 20-bit signed.
- SAT: clamp sum to 0..511, register it to AssistanceRequirement, pulse out_valid.
- Latency: hr_valid sampled in cycle N gives out_valid in cycle N+5.
- hr_valid while busy=1: dropped, no queueing, no effect on the FSM.
- Tilt fault: |resolvedRoll| > TILT_LIMIT or |resolvedPitch| > TILT_LIMIT, compared every cycle. Magnitude of -512 is treated as 512.
  - On the next clk: fault=1, AssistanceRequirement=0, integ=0, FSM aborts to IDLE (no out_valid).
  - fault clears only when both angles are within the limit at an hr_valid accepted in IDLE. That sample then computes normally.
- Brake=1, checked every cycle:
  - AssistanceRequirement forced to 0 on the next clk.
  - integ frozen (INTEG state skips the update).
  - FSM still runs and out_valid still pulses, with output 0.
- Cadence:
  - A counter resets on each synchronised rising edge of cadence.
  - When the counter reaches CAD_TIMEOUT: stalled=1, integ=0, output held at 0. The counter saturates and does not wrap.
  - The first cadence edge clears stalled on the next clk.
- Priority when events coincide: tilt fault > stall > brake > normal update. A fault arriving in the same cycle as SAT wins: output 0, no out_valid.
- While fault=1 or stalled=1, each accepted update still pulses out_valid with value 0, except the cycle that aborts on fault.

Optional Feature:
ASSIST_RAMP_LIMIT_EN
- Defined: SAT limits the output change to +/-RAMP_STEP per update relative to the previous AssistanceRequirement. Forced-zero events (fault, stall, brake) bypass the ramp and go to 0 immediately.
- Undefined: the saturated value is applied directly.

Test Plan:
1. Reset, drive one cadence edge, SP=120, HR=130, hr_valid -> out_valid at N+5, AssistanceRequirement=22 (P=20, I=10>>>2=2).
2. Repeat the HR=130 update -> integ=20, output=25. Then HR=100 -> err=-20, integ=0, output 0 (clamped, not negative).
3. Mid-computation (cycle N+3), resolvedRoll=200 -> next clk: output 0, fault=1, no out_valid. Roll=10 with hr_valid -> fault=0, output from integ=0.
4. brake=1 during SP=120/HR=140 updates -> output 0 on every out_valid, integ unchanged. Release brake -> output resumes from the frozen integ.
5. No cadence edge for CAD_TIMEOUT (override to 100) cycles -> stalled=1, integ=0, output 0. One cadence edge -> stalled=0 next clk.
6. With ASSIST_RAMP_LIMIT_EN, output 0 and target 100 -> successive outputs 16, 32, 48...; tilt fault -> output 0 immediately.

Source files
------------

// File: rtl/assist_pi_sequencer.sv
// Heart-rate PI assistance sequencer with tilt, brake and cadence-stall interlocks.
// Define ASSIST_RAMP_LIMIT_EN to slew-limit the output by RAMP_STEP per update.
module assist_pi_sequencer #(
    parameter int unsigned KP          = 2,
    parameter int unsigned KI          = 1,
    parameter int unsigned I_SHIFT     = 2,
    parameter int unsigned INT_LIMIT   = 2000,
    parameter int unsigned TILT_LIMIT  = 128,
    parameter int unsigned CAD_TIMEOUT = 50000000,
    parameter int unsigned RAMP_STEP   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hr_valid,
    input  logic [7:0]        HeartRate,
    input  logic [7:0]        HeartRateSetPoint,
    input  logic signed [9:0] resolvedRoll,
    input  logic signed [9:0] resolvedPitch,
    input  logic              cadence,
    input  logic              brake,
    output logic signed [9:0] AssistanceRequirement,
    output logic              out_valid,
    output logic              busy,
    output logic              fault,
    output logic              stalled
);
    localparam int unsigned CW = $clog2(CAD_TIMEOUT + 1);
`ifdef ASSIST_RAMP_LIMIT_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif
    localparam logic signed [16:0] ILIM  = 17'(INT_LIMIT);
    localparam logic signed [19:0] KP_S  = 20'(KP);
    localparam logic signed [19:0] KI_S  = 20'(KI);
    localparam logic [10:0]        TLIM  = 11'(TILT_LIMIT);
    localparam logic signed [10:0] RSTEP = 11'(RAMP_STEP);

    typedef enum logic [2:0] {IDLE, SAMPLE, ERR, INTEG, SUM, SAT} state_t;

    state_t             state, state_d;
    logic [7:0]         hr_q, sp_q, hr_d, sp_d;
    logic signed [8:0]  err_q, err_d, err_calc;
    logic signed [15:0] integ, integ_d, integ_clamp;
    logic signed [16:0] integ_sum;
    logic signed [19:0] sum_q, sum_d, p_term, i_prod, i_term, sum_calc;
    logic signed [9:0]  sat_val, ramp_val, out_calc, out_d;
    logic signed [10:0] delta;
    logic               valid_d, fault_d;
    logic signed [10:0] roll_x, pitch_x;
    logic [10:0]        roll_mag, pitch_mag;
    logic               tilt;
    logic [2:0]         cad_s;
    logic               cad_rise;
    logic [CW-1:0]      cad_cnt;

    // Angle magnitudes widened so that -512 maps to +512.
    assign roll_x    = {resolvedRoll[9], resolvedRoll};
    assign pitch_x   = {resolvedPitch[9], resolvedPitch};
    assign roll_mag  = roll_x[10]  ? 11'(-roll_x)  : 11'(roll_x);
    assign pitch_mag = pitch_x[10] ? 11'(-pitch_x) : 11'(pitch_x);
    assign tilt      = (roll_mag > TLIM) || (pitch_mag > TLIM);

    // PI arithmetic; each stage reads the register written on entry to the current state.
    assign err_calc  = $signed({1'b0, hr_q}) - $signed({1'b0, sp_q});
    assign integ_sum = $signed({integ[15], integ}) + $signed({{8{err_q[8]}}, err_q});
    assign p_term    = KP_S * $signed({{11{err_q[8]}}, err_q});
    assign i_prod    = KI_S * $signed({{4{integ[15]}}, integ});
    assign i_term    = i_prod >>> I_SHIFT;
    assign sum_calc  = p_term + i_term;

    always_comb begin
        if (integ_sum > ILIM)
            integ_clamp = 16'(ILIM);
        else if (integ_sum < -ILIM)
            integ_clamp = 16'(-ILIM);
        else
            integ_clamp = integ_sum[15:0];
    end

    always_comb begin
        if (sum_q < 20'sd0)
            sat_val = 10'sd0;
        else if (sum_q > 20'sd511)
            sat_val = 10'sd511;
        else
            sat_val = $signed(sum_q[9:0]);
    end

    assign delta = {sat_val[9], sat_val} - {AssistanceRequirement[9], AssistanceRequirement};

    always_comb begin
        if (delta > RSTEP)
            ramp_val = AssistanceRequirement + 10'(RSTEP);
        else if (delta < -RSTEP)
            ramp_val = AssistanceRequirement - 10'(RSTEP);
        else
            ramp_val = sat_val;
    end

    assign out_calc = RAMP_EN ? ramp_val : sat_val;

    // Next state and datapath; interlocks override in priority order tilt > stall > brake.
    always_comb begin
        state_d = state;
        hr_d    = hr_q;
        sp_d    = sp_q;
        err_d   = err_q;
        integ_d = integ;
        sum_d   = sum_q;
        out_d   = AssistanceRequirement;
        valid_d = 1'b0;
        fault_d = fault;
        case (state)
            IDLE: begin
                if (hr_valid) begin
                    hr_d    = HeartRate;
                    sp_d    = HeartRateSetPoint;
                    fault_d = 1'b0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                err_d   = err_calc;
                state_d = ERR;
            end
            ERR: begin
                if (!brake)
                    integ_d = integ_clamp;
                state_d = INTEG;
            end
            INTEG: begin
                sum_d   = sum_calc;
                state_d = SUM;
            end
            SUM: begin
                out_d   = out_calc;
                valid_d = 1'b1;
                state_d = SAT;
            end
            SAT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (brake)
            out_d = '0;
        if (stalled) begin
            out_d   = '0;
            integ_d = '0;
        end
        if (tilt) begin
            fault_d = 1'b1;
            out_d   = '0;
            integ_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_q                  <= '0;
            sp_q                  <= '0;
            err_q                 <= '0;
            integ                 <= '0;
            sum_q                 <= '0;
            AssistanceRequirement <= '0;
            out_valid             <= 1'b0;
            busy                  <= 1'b0;
            fault                 <= 1'b0;
        end else begin
            hr_q                  <= hr_d;
            sp_q                  <= sp_d;
            err_q                 <= err_d;
            integ                 <= integ_d;
            sum_q                 <= sum_d;
            AssistanceRequirement <= out_d;
            out_valid             <= valid_d;
            busy                  <= (state_d != IDLE);
            fault                 <= fault_d;
        end
    end

    // Cadence synchroniser and saturating stall counter.
    assign cad_rise = cad_s[1] & ~cad_s[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cad_s   <= '0;
            cad_cnt <= '0;
            stalled <= 1'b1;
        end else begin
            cad_s <= {cad_s[1:0], cadence};
            if (cad_rise) begin
                cad_cnt <= '0;
                stalled <= 1'b0;
            end else if (cad_cnt != CW'(CAD_TIMEOUT)) begin
                cad_cnt <= cad_cnt + CW'(1);
            end else begin
                stalled <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_assist_pi_sequencer.sv
// Directed bench for assist_pi_sequencer: arithmetic model plus per-cycle out_valid/value checking.
module tb_assist_pi_sequencer;
    localparam int KP = 2, KI = 1, I_SHIFT = 2, INT_LIMIT = 2000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hr_valid = 1'b0;
    logic [7:0]        HeartRate = '0;
    logic [7:0]        HeartRateSetPoint = '0;
    logic signed [9:0] resolvedRoll = '0;
    logic signed [9:0] resolvedPitch = '0;
    logic              cadence = 1'b0;
    logic              brake = 1'b0;
    logic signed [9:0] AssistanceRequirement;
    logic              out_valid, busy, fault, stalled;

    assist_pi_sequencer #(.CAD_TIMEOUT(100)) dut (
        .clk(clk), .rst_n(rst_n), .hr_valid(hr_valid), .HeartRate(HeartRate),
        .HeartRateSetPoint(HeartRateSetPoint), .resolvedRoll(resolvedRoll),
        .resolvedPitch(resolvedPitch), .cadence(cadence), .brake(brake),
        .AssistanceRequirement(AssistanceRequirement), .out_valid(out_valid),
        .busy(busy), .fault(fault), .stalled(stalled)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int val; } exp_t;
    exp_t q[$];
    int   tests = 0, fails = 0, cyc = 0;
    int   m_integ = 0;
    bit   m_stalled = 1'b0;
    bit   chk_en = 1'b0;
    bit   cad_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int floor_shift(input int x);
        int d = 1 << I_SHIFT;
        return (x >= 0) ? x / d : -((-x + d - 1) / d);
    endfunction

    // One PI update from the rules: interlocks first, then clamped integral and output.
    function automatic int model_update(input int hr, input int sp);
        int e, s;
        if (m_stalled) begin
            m_integ = 0;
            return 0;
        end
        e = hr - sp;
        if (!brake) begin
            m_integ = m_integ + e;
            if (m_integ > INT_LIMIT) m_integ = INT_LIMIT;
            if (m_integ < -INT_LIMIT) m_integ = -INT_LIMIT;
        end
        s = KP * e + floor_shift(KI * m_integ);
        if (brake || s < 0) return 0;
        return (s > 511) ? 511 : s;
    endfunction

    // Every cycle: out_valid exactly when a modelled update is due, with its value.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                check("out_valid", int'(out_valid), 1);
                check("assist_value", int'(AssistanceRequirement), q[0].val);
                void'(q.pop_front());
            end else begin
                check("no_out_valid", int'(out_valid), 0);
            end
        end
    end

    // Background cadence pulses keep the stall detector quiet.
    initial begin
        forever begin
            repeat (30) @(posedge clk);
            #1 if (cad_en) cadence = 1'b1;
            repeat (5) @(posedge clk);
            #1 if (cad_en) cadence = 1'b0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_update(input int hr, input int sp, input bit poke);
        exp_t e;
        @(posedge clk); #1;
        HeartRate = 8'(hr);
        HeartRateSetPoint = 8'(sp);
        hr_valid = 1'b1;
        @(posedge clk); #1;
        hr_valid = 1'b0;
        e.due = cyc + 4;
        e.val = model_update(hr, sp);
        q.push_back(e);
        @(posedge clk); #1;
        if (poke) begin
            HeartRate = 8'd250;
            HeartRateSetPoint = 8'd0;
            hr_valid = 1'b1;
        end
        @(posedge clk); #1;
        hr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_stalled(input logic val, input int budget, output int n);
        n = 0;
        while (stalled !== val && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_assist", int'(AssistanceRequirement), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_stalled", int'(stalled), 1);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Cadence edge clears the power-on stall.
        wait_stalled(1'b0, 200, n);
        check("initial_stall_clear", int'(n < 200), 1);

        // Basic updates, latency and dropped strobe while busy.
        check("idle_busy", int'(busy), 0);
        do_update(130, 120, 1'b0);
        check("lit_first_22", int'(AssistanceRequirement), 22);
        do_update(130, 120, 1'b1);
        check("lit_second_25", int'(AssistanceRequirement), 25);
        do_update(100, 120, 1'b0);
        check("lit_neg_clamp_0", int'(AssistanceRequirement), 0);

        // Integrator clamp at both limits.
        for (int i = 0; i < 9; i++) do_update(255, 0, 1'b0);
        check("lit_sat_511", int'(AssistanceRequirement), 511);
        for (int i = 0; i < 20; i++) do_update(0, 255, 1'b0);
        check("lit_low_0", int'(AssistanceRequirement), 0);
        do_update(255, 0, 1'b0);
        check("lit_from_neg_limit_73", int'(AssistanceRequirement), 73);

        // Tilt abort mid-computation.
        @(posedge clk); #1;
        HeartRate = 8'd130; HeartRateSetPoint = 8'd120; hr_valid = 1'b1;
        @(posedge clk); #1;
        hr_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        repeat (2) @(posedge clk);
        #1 resolvedRoll = 10'sd200;
        @(posedge clk); #1;
        m_integ = 0;
        check("tilt_fault", int'(fault), 1);
        check("tilt_assist", int'(AssistanceRequirement), 0);
        check("tilt_busy", int'(busy), 0);
        resolvedRoll = -10'sd128;
        resolvedPitch = 10'sd128;
        repeat (4) @(posedge clk);
        #1 check("fault_held_until_update", int'(fault), 1);
        do_update(130, 120, 1'b0);
        check("fault_cleared", int'(fault), 0);
        check("lit_after_fault_22", int'(AssistanceRequirement), 22);
        resolvedPitch = 10'h200;
        repeat (2) @(posedge clk);
        #1;
        m_integ = 0;
        check("tilt_minus512", int'(fault), 1);
        check("tilt_minus512_assist", int'(AssistanceRequirement), 0);
        resolvedPitch = '0;
        resolvedRoll = '0;
        do_update(130, 120, 1'b0);
        check("lit_refault_22", int'(AssistanceRequirement), 22);

        // Brake forces zero and freezes the integrator.
        brake = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("brake_zero", int'(AssistanceRequirement), 0);
        do_update(140, 120, 1'b0);
        do_update(140, 120, 1'b0);
        brake = 1'b0;
        do_update(140, 120, 1'b0);
        check("lit_brake_release_47", int'(AssistanceRequirement), 47);

        // Cadence stall.
        cad_en = 1'b0;
        repeat (6) @(posedge clk);
        #1 cadence = 1'b0;
        wait_stalled(1'b1, 400, n);
        check("stall_seen", int'(n < 400), 1);
        check("stall_not_early", int'(n >= 50), 1);
        m_stalled = 1'b1;
        m_integ = 0;
        @(posedge clk); #1;
        check("stall_assist_zero", int'(AssistanceRequirement), 0);
        do_update(130, 120, 1'b0);
        check("stall_update_zero", int'(AssistanceRequirement), 0);
        cadence = 1'b1;
        wait_stalled(1'b0, 6, n);
        check("stall_cleared", int'(n < 6), 1);
        m_stalled = 1'b0;
        cadence = 1'b0;
        cad_en = 1'b1;
        do_update(130, 120, 1'b0);
        check("lit_after_stall_22", int'(AssistanceRequirement), 22);

        repeat (4) @(posedge clk);
        #1 check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
